// File: rtl/rx78_cart_loader.sv
// rx78_cart_loader -- streams a cartridge image from the HPS ioctl port into
// CPU address space through a 4-entry FIFO, and holds the core in reset until
// the image has landed.
// Optional feature: define RX78_CART_FILL_EN to pad the rest of the cartridge
// window with 8'hFF after the download, before the core is released.
//
// Upload handshake: upload_we is high whenever a write is pending; upload_addr
// and upload_data hold steady until a cycle with upload_we=1 and upload_rdy=1,
// which is the only cycle in which the pending write is consumed.
module rx78_cart_loader #(
  parameter logic [15:0] CART_BASE  = 16'h2000,
  parameter int          CART_MAX   = 24576,
  parameter logic [7:0]  CART_INDEX = 8'd1,
  parameter int          HOLD_EXT   = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] upload_addr,
  output logic [7:0]  upload_data,
  output logic        upload_we,
  input  logic        upload_rdy,
  output logic        cpu_reset,
  output logic [15:0] cart_size,
  output logic        cart_valid,
  output logic        overflow
);

  localparam logic [24:0] MAX_ADDR  = 25'(CART_MAX);
  localparam logic [15:0] MAX_SIZE  = 16'(CART_MAX);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_EXT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3
`ifdef RX78_CART_FILL_EN
    , S_FILL = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;

  // FIFO entry layout: {cpu_addr[15:0], data[7:0]}
  logic [23:0] fifo_mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;

  logic [15:0] cart_size_q;
  logic        cart_valid_q, overflow_q, cpu_reset_q;
  logic        boot_q;    // release after reset still pending
  logic        loaded_q;  // the HOLD in progress follows a cartridge load
  logic [15:0] hold_cnt_q;

  logic        cart_sel, enter_load, fifo_empty, fifo_full;
  logic        wr_req, in_range, push, drop, pop, hold_done;
  logic [16:0] byte_end;

  assign cart_sel   = ioctl_download && (ioctl_index == CART_INDEX);
  assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);
  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign wr_req     = (state_q == S_LOAD) && ioctl_wr;
  assign in_range   = (ioctl_addr < MAX_ADDR);
  assign push       = wr_req && in_range && !fifo_full;
  assign drop       = wr_req && !(in_range && !fifo_full);
  assign pop        = !fifo_empty && upload_rdy;
  assign hold_done  = (hold_cnt_q == HOLD_LAST);
  // Accepted addresses are below CART_MAX, so addr+1 never exceeds CART_MAX.
  assign byte_end   = {1'b0, ioctl_addr[15:0]} + 17'd1;

`ifdef RX78_CART_FILL_EN
  logic [15:0] fill_ptr_q;
  logic        fill_done, fill_take;
  assign fill_done = (fill_ptr_q == MAX_SIZE);
  assign fill_take = (state_q == S_FILL) && !fill_done && upload_rdy;
`endif

  // State register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a new cartridge download pre-empts any post-load phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cart_sel)    state_d = S_LOAD;
        else if (boot_q) state_d = S_HOLD;
      end
      S_LOAD: begin
        if (!ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cart_sel) state_d = S_LOAD;
`ifdef RX78_CART_FILL_EN
        else if (fifo_empty) state_d = S_FILL;
`else
        else if (fifo_empty) state_d = S_HOLD;
`endif
      end
`ifdef RX78_CART_FILL_EN
      S_FILL: begin
        if (cart_sel)       state_d = S_LOAD;
        else if (fill_done) state_d = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (cart_sel)       state_d = S_LOAD;
        else if (hold_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: FIFO head drives the upload port; FILL takes over once drained
  always_comb begin
    ioctl_wait  = (count_q >= 3'd3);
    upload_we   = 1'b0;
    upload_addr = 16'h0000;
    upload_data = 8'h00;
    if (!fifo_empty) begin
      upload_we   = 1'b1;
      upload_addr = fifo_mem[rd_ptr_q][23:8];
      upload_data = fifo_mem[rd_ptr_q][7:0];
    end
`ifdef RX78_CART_FILL_EN
    else if ((state_q == S_FILL) && !fill_done) begin
      upload_we   = 1'b1;
      upload_addr = CART_BASE + fill_ptr_q;
      upload_data = 8'hFF;
    end
`endif
  end

  assign cpu_reset  = cpu_reset_q;
  assign cart_size  = cart_size_q;
  assign cart_valid = cart_valid_q;
  assign overflow   = overflow_q;

  // FIFO storage: written on every accepted byte, already relocated to CPU space
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_q] <= {CART_BASE + ioctl_addr[15:0], ioctl_dout};
  end

  // FIFO pointers and occupancy; entering LOAD discards anything left over
  always_ff @(posedge clk_sys) begin
    if (!reset_n || enter_load) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + 3'(push) - 3'(pop);
    end
  end

  // Cartridge status: cleared on each load, core released when HOLD expires
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cart_size_q  <= 16'h0000;
      cart_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      boot_q       <= 1'b1;
      loaded_q     <= 1'b0;
    end else if (enter_load) begin
      cart_size_q  <= 16'h0000;
      cart_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      boot_q       <= 1'b0;
      loaded_q     <= 1'b1;
    end else begin
      if (push && (byte_end > {1'b0, cart_size_q})) cart_size_q <= byte_end[15:0];
      if (drop) overflow_q <= 1'b1;
      if ((state_q == S_HOLD) && (state_d == S_IDLE)) begin
        cpu_reset_q  <= 1'b0;
        cart_valid_q <= loaded_q;
        boot_q       <= 1'b0;
        loaded_q     <= 1'b0;
      end
    end
  end

  // HOLD duration counter, restarts from zero on every entry to HOLD
  always_ff @(posedge clk_sys) begin
    if (!reset_n || (state_q != S_HOLD)) hold_cnt_q <= 16'h0000;
    else                                 hold_cnt_q <= hold_cnt_q + 16'd1;
  end

`ifdef RX78_CART_FILL_EN
  // Fill pointer: starts just past the loaded image, advances per accepted write
  always_ff @(posedge clk_sys) begin
    if (!reset_n)                fill_ptr_q <= 16'h0000;
    else if (state_q == S_DRAIN) fill_ptr_q <= cart_size_q;
    else if (fill_take)          fill_ptr_q <= fill_ptr_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rx78_cart_loader.sv
// tb_rx78_cart_loader -- directed/randomised bench for rx78_cart_loader.
// The reference model tracks the loader at transaction level: an expected
// write queue, a FIFO occupancy number, the largest accepted offset and an
// overflow flag, all derived from the bytes the bench itself sends.
// Define RX78_CART_FILL_EN to exercise the 8'hFF fill phase instead of the
// default scenario list.
module tb_rx78_cart_loader;

  localparam logic [15:0] CART_BASE  = 16'h2000;
  localparam int          CART_MAX   = 24576;
  localparam logic [7:0]  CART_INDEX = 8'd1;
  localparam int          HOLD_EXT   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] upload_addr;
  logic [7:0]  upload_data;
  logic        upload_we;
  logic        upload_rdy;
  logic        cpu_reset;
  logic [15:0] cart_size;
  logic        cart_valid;
  logic        overflow;

  always #5 clk_sys = ~clk_sys;

  rx78_cart_loader #(
    .CART_BASE  (CART_BASE),
    .CART_MAX   (CART_MAX),
    .CART_INDEX (CART_INDEX),
    .HOLD_EXT   (HOLD_EXT)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .upload_addr    (upload_addr),
    .upload_data    (upload_data),
    .upload_we      (upload_we),
    .upload_rdy     (upload_rdy),
    .cpu_reset      (cpu_reset),
    .cart_size      (cart_size),
    .cart_valid     (cart_valid),
    .overflow       (overflow)
  );

  // ---------------- bookkeeping ----------------
  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int rdy_mode = 0;          // 0: sink always ready, 1: ready one cycle in four

  // scoreboard / reference model
  logic [23:0] exp_q[$];     // {cpu_addr, data} in the order writes must appear
  int occ = 0;               // model FIFO occupancy
  int dut_wr = 0;            // upload handshakes seen on the port
  int model_size = 0;        // max(offset)+1 over accepted bytes
  bit model_ovf = 1'b0;      // some byte of the current load was dropped
  bit saw_three = 1'b0;      // model occupancy reached 3 during the load
  bit fill_active = 1'b0;
  int fill_next = 0;
  int nfill = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    upload_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
  endtask

  task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 1000) begin
      ioctl_wr = 1'b0;
      step();
      guard++;
    end
    if (guard >= 1000) chk("wait_bound", 32'(guard), 32'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
  endtask

  task automatic begin_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == CART_INDEX) begin
      model_size = 0;
      model_ovf  = 1'b0;
      saw_three  = 1'b0;
    end
    step();
    step();
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) put_byte(25'(i), 8'($urandom));
    ioctl_wr = 1'b0;
  endtask

  // Let the FIFO empty with download still high, then close the window.
  task automatic end_load();
    int g = 0;
    while (upload_we && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) chk("drain_bound", 32'(g), 32'd0);
    ioctl_download = 1'b0;
  endtask

  // Edges from now until cpu_reset is seen low.
  task automatic measure_fall(input string tag, input int exp_edges, input int bound);
    int n = 0;
    while (cpu_reset === 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_edges));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_sys) begin
    logic [23:0] e;
    bit pop_m, push_m;
    if (!reset_n) begin
      occ = 0;
      exp_q.delete();
    end else begin
      if (!fill_active) begin
        chk("ioctl_wait", 32'(ioctl_wait), 32'(occ >= 3));
        chk("upload_we", 32'(upload_we), 32'(occ != 0));
      end
      if (upload_we && upload_rdy) dut_wr++;
      pop_m = (occ != 0) && upload_rdy;
      if (pop_m) begin
        e = exp_q.pop_front();
        chk("upload_beat", 32'({upload_addr, upload_data}), 32'(e));
      end else if (fill_active && upload_we && upload_rdy) begin
        chk("fill_beat", 32'({upload_addr, upload_data}),
            32'({CART_BASE + 16'(fill_next), 8'hFF}));
        fill_next++;
        nfill++;
      end
      push_m = ioctl_download && (ioctl_index == CART_INDEX) && ioctl_wr &&
               (ioctl_addr < 25'(CART_MAX)) && (occ < 4);
      if (ioctl_download && (ioctl_index == CART_INDEX) && ioctl_wr && !push_m)
        model_ovf = 1'b1;
      if (push_m) begin
        exp_q.push_back({CART_BASE + ioctl_addr[15:0], ioctl_dout});
        if (int'(ioctl_addr) + 1 > model_size) model_size = int'(ioctl_addr) + 1;
      end
      occ = occ + int'(push_m) - int'(pop_m);
      if (occ >= 3) saw_three = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (200000) @(posedge clk_sys);
    $display("FAIL watchdog: observed no end of test, expected $finish within 200000 cycles");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w0;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    upload_rdy     = 1'b1;
    repeat (3) step();

    // reset state
    chk("rst_wait",      32'(ioctl_wait), 32'd0);
    chk("rst_we",        32'(upload_we), 32'd0);
    chk("rst_addr",      32'(upload_addr), 32'd0);
    chk("rst_data",      32'(upload_data), 32'd0);
    chk("rst_size",      32'(cart_size), 32'd0);
    chk("rst_valid",     32'(cart_valid), 32'd0);
    chk("rst_overflow",  32'(overflow), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);

    // release: one IDLE cycle to start the hold, then HOLD_EXT cycles of HOLD
    reset_n = 1'b1;
    measure_fall("boot_hold", HOLD_EXT + 1, 200);
    chk("boot_valid", 32'(cart_valid), 32'd0);

`ifdef RX78_CART_FILL_EN
    // 4-byte load, then 0xFF over 0x2004..0x7FFF
    rdy_mode = 0;
    begin_load(CART_INDEX);
    send_bytes(4);
    end_load();
    fill_active = 1'b1;
    fill_next   = model_size;
    nfill       = 0;
    // LOAD sees download low, DRAIN sees empty, one FILL cycle per write,
    // one FILL cycle to see the end, then HOLD_EXT cycles of HOLD
    measure_fall("fill_hold", 3 + (CART_MAX - 4) + HOLD_EXT, 30000);
    fill_active = 1'b0;
    chk("fill_count", 32'(nfill), 32'(CART_MAX - 4));
    chk("fill_end",   32'(fill_next), 32'(CART_MAX));
    chk("fill_size",  32'(cart_size), 32'(model_size));
    chk("fill_valid", 32'(cart_valid), 32'd1);
`else
    // 16-byte load, sink always ready
    rdy_mode = 0;
    w0 = dut_wr;
    begin_load(CART_INDEX);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
    send_bytes(16);
    end_load();
    // LOAD sees download low, DRAIN sees the FIFO empty, then HOLD_EXT of HOLD
    measure_fall("t1_hold", HOLD_EXT + 2, 200);
    chk("t1_writes",   32'(dut_wr - w0), 32'd16);
    chk("t1_size",     32'(cart_size), 32'(model_size));
    chk("t1_valid",    32'(cart_valid), 32'd1);
    chk("t1_overflow", 32'(overflow), 32'(model_ovf));

    // same load with a sink ready one cycle in four
    rdy_mode = 1;
    w0 = dut_wr;
    begin_load(CART_INDEX);
    chk("t2_valid_cleared", 32'(cart_valid), 32'd0);
    chk("t2_cpu_reset",     32'(cpu_reset), 32'd1);
    send_bytes(16);
    end_load();
    chk("t2_reached_three", 32'(saw_three), 32'd1);
    measure_fall("t2_hold", HOLD_EXT + 2, 200);
    chk("t2_writes",   32'(dut_wr - w0), 32'd16);
    chk("t2_size",     32'(cart_size), 32'(model_size));
    chk("t2_overflow", 32'(overflow), 32'd0);
    chk("t2_valid",    32'(cart_valid), 32'd1);

    // download of a different file index is ignored
    rdy_mode = 0;
    w0 = dut_wr;
    begin_load(8'd2);
    send_bytes(8);
    end_load();
    repeat (4) step();
    chk("idx2_writes",    32'(dut_wr - w0), 32'd0);
    chk("idx2_valid",     32'(cart_valid), 32'd1);
    chk("idx2_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("idx2_size",      32'(cart_size), 32'd16);
    chk("idx2_overflow",  32'(overflow), 32'd0);

    // file one byte longer than the window
    w0 = dut_wr;
    begin_load(CART_INDEX);
    send_bytes(CART_MAX + 1);
    end_load();
    chk("big_overflow", 32'(overflow), 32'(model_ovf));
    chk("big_size",     32'(cart_size), 32'(model_size));
    chk("big_writes",   32'(dut_wr - w0), 32'(CART_MAX));
    measure_fall("big_hold", HOLD_EXT + 2, 200);
    chk("big_valid",    32'(cart_valid), 32'd1);

    // reset in the middle of a load
    rdy_mode = 1;
    begin_load(CART_INDEX);
    send_bytes(5);
    reset_n = 1'b0;
    step();
    chk("mid_rst_we",        32'(upload_we), 32'd0);
    chk("mid_rst_wait",      32'(ioctl_wait), 32'd0);
    chk("mid_rst_valid",     32'(cart_valid), 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_size",      32'(cart_size), 32'd0);
    chk("mid_rst_addr",      32'(upload_addr), 32'd0);
    ioctl_download = 1'b0;
    step();
    step();
    rdy_mode = 0;
    reset_n  = 1'b1;
    measure_fall("mid_rst_hold", HOLD_EXT + 1, 200);
    chk("mid_rst_valid_after", 32'(cart_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
